// File: rtl/tt_um_priority_event_fifo_if.sv
// Pin bundle between the encoder/host side and the event FIFO.
// The master drives inputs; the slave (FIFO) drives outputs.
interface tt_um_priority_event_fifo_if;
  logic       ena;
  logic [7:0] ui_in;
  logic [7:0] uio_in;
  logic [7:0] uo_out;
  logic [7:0] uio_out;
  logic [7:0] uio_oe;

  modport master (
    output ena,
    output ui_in,
    output uio_in,
    input  uo_out,
    input  uio_out,
    input  uio_oe
  );

  modport slave (
    input  ena,
    input  ui_in,
    input  uio_in,
    output uo_out,
    output uio_out,
    output uio_oe
  );
endinterface

// File: rtl/tt_um_priority_event_fifo.sv
// Priority-change event FIFO: queues each new winning encoder index
// and lets the host drain the history with a synchronised pop strobe.
module tt_um_priority_event_fifo #(
  parameter int         DEPTH     = 8,
  parameter logic [7:0] IDLE_CODE = 8'hF0
) (
  input logic                       clk,
  input logic                       rst_n,
  tt_um_priority_event_fifo_if.slave bus
);

  localparam int         PW       = $clog2(DEPTH);
  localparam logic [3:0] FULL_CNT = 4'(DEPTH);

  logic [7:0]    code_q;
  logic [7:0]    code_prev;
  logic [1:0]    sync1;
  logic [1:0]    sync2;
  logic [1:0]    sync3;
  logic [3:0]    mem [DEPTH];
  logic [PW-1:0] rd_ptr;
  logic [PW-1:0] wr_ptr;
  logic [3:0]    count;
  logic          ovf;
  logic          unf;
  logic          bad;

  logic       valid;
  logic       push_req;
  logic       bad_now;
  logic       pop_req;
  logic       clr_req;
  logic       is_full;
  logic       is_empty;
  logic       do_push;
  logic       do_pop;
  logic [3:0] head;
  logic       unused_pins;

  assign valid    = code_q[7:4] == 4'h0;
  assign push_req = valid && (code_q != code_prev);
  assign bad_now  = !valid && (code_q != IDLE_CODE);
  assign pop_req  = sync2[0] & ~sync3[0];
  assign clr_req  = sync2[1] & ~sync3[1];
  assign is_full  = count == FULL_CNT;
  assign is_empty = count == 4'd0;
  // When full, a concurrent pop frees the slot the push lands in.
  assign do_push  = push_req && (!is_full || pop_req);
  assign do_pop   = pop_req && !is_empty;

  // Sample the encoder code and synchronise the host strobes.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      code_q    <= IDLE_CODE;
      code_prev <= IDLE_CODE;
      sync1     <= 2'b00;
      sync2     <= 2'b00;
      sync3     <= 2'b00;
    end else begin
      code_q    <= bus.ui_in;
      code_prev <= clr_req ? IDLE_CODE : code_q;
      sync1     <= bus.uio_in[1:0];
      sync2     <= sync1;
      sync3     <= sync2;
    end
  end

  // FIFO storage, pointers, occupancy and sticky status flags.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= 4'h0;
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= 4'd0;
      ovf    <= 1'b0;
      unf    <= 1'b0;
      bad    <= 1'b0;
    end else if (clr_req) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= 4'd0;
      ovf    <= 1'b0;
      unf    <= 1'b0;
      bad    <= 1'b0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= code_q[3:0];
        wr_ptr      <= wr_ptr + PW'(1);
      end
      if (do_pop) rd_ptr <= rd_ptr + PW'(1);
      if (do_push && !do_pop) count <= count + 4'd1;
      else if (do_pop && !do_push) count <= count - 4'd1;
      if (push_req && is_full && !pop_req) ovf <= 1'b1;
      if (pop_req && is_empty) unf <= 1'b1;
      if (bad_now) bad <= 1'b1;
    end
  end

  assign head = is_empty ? 4'h0 : mem[rd_ptr];

  assign bus.uo_out  = {bad, ovf, is_full, !is_empty, head};
  assign bus.uio_out = {1'b0, count, unf, 2'b00};
  assign bus.uio_oe  = 8'hFC;

  assign unused_pins = &{1'b0, bus.ena, bus.uio_in[7:2]};

endmodule

// File: tb/tb_tt_um_priority_event_fifo.sv
// Directed bench for the priority event FIFO with
// hand-computed expectations for each scenario.
module tb_tt_um_priority_event_fifo;

  localparam logic [7:0] IDLE = 8'hF0;

  logic clk;
  logic rst_n;
  int   n_chk;
  int   n_pass;

  tt_um_priority_event_fifo_if bus ();

  tt_um_priority_event_fifo dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic tick(int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic push(logic [7:0] code);
    bus.ui_in = code;
    tick(1);
    bus.ui_in = IDLE;
    tick(1);
  endtask

  task automatic pop();
    bus.uio_in[0] = 1'b1;
    tick(1);
    bus.uio_in[0] = 1'b0;
    tick(3);
  endtask

  task automatic clear();
    bus.uio_in[1] = 1'b1;
    tick(1);
    bus.uio_in[1] = 1'b0;
    tick(3);
  endtask

  function automatic logic [3:0] cnt();
    return bus.uio_out[6:3];
  endfunction

  initial begin
    n_chk      = 0;
    n_pass     = 0;
    rst_n      = 1'b0;
    bus.ena    = 1'b1;
    bus.ui_in  = IDLE;
    bus.uio_in = 8'h00;
    tick(3);
    check("rst_uo", 32'(bus.uo_out), 32'h00);
    rst_n = 1'b1;
    tick(10);
    check("idle_uo", 32'(bus.uo_out), 32'h00);
    check("idle_uio", 32'(bus.uio_out), 32'h00);
    check("idle_oe", 32'(bus.uio_oe), 32'hFC);

    bus.ui_in = 8'h05;
    tick(5);
    bus.ui_in = IDLE;
    tick(2);
    bus.ui_in = 8'h0C;
    tick(1);
    bus.ui_in = IDLE;
    tick(2);
    check("t2_cnt", 32'(cnt()), 32'd2);
    check("t2_head", 32'(bus.uo_out[3:0]), 32'h5);
    check("t2_ne", 32'(bus.uo_out[4]), 32'd1);
    pop();
    check("t2_head_pop", 32'(bus.uo_out[3:0]), 32'hC);
    check("t2_cnt_pop", 32'(cnt()), 32'd1);
    pop();
    check("t2_empty", 32'(bus.uo_out), 32'h00);

    for (int i = 1; i <= 9; i++) push(8'(i));
    check("t3_cnt", 32'(cnt()), 32'd8);
    check("t3_full", 32'(bus.uo_out[5]), 32'd1);
    check("t3_ovf", 32'(bus.uo_out[6]), 32'd1);
    for (int i = 1; i <= 8; i++) begin
      check($sformatf("t3_head%0d", i), 32'(bus.uo_out[3:0]), 32'(i));
      pop();
    end
    check("t3_cnt_end", 32'(cnt()), 32'd0);
    check("t3_ne_end", 32'(bus.uo_out[4]), 32'd0);

    pop();
    check("t4_unf", 32'(bus.uio_out[2]), 32'd1);
    check("t4_cnt", 32'(cnt()), 32'd0);
    clear();
    check("t4_clr_uo", 32'(bus.uo_out), 32'h00);
    check("t4_clr_uio", 32'(bus.uio_out), 32'h00);

    for (int i = 1; i <= 8; i++) push(8'(i));
    check("t5_cnt_full", 32'(cnt()), 32'd8);
    check("t5_ovf_pre", 32'(bus.uo_out[6]), 32'd0);
    bus.uio_in[0] = 1'b1;
    tick(1);
    bus.uio_in[0] = 1'b0;
    bus.ui_in = 8'h0A;
    tick(1);
    bus.ui_in = IDLE;
    tick(4);
    check("t5_cnt", 32'(cnt()), 32'd8);
    check("t5_ovf", 32'(bus.uo_out[6]), 32'd0);
    check("t5_full", 32'(bus.uo_out[5]), 32'd1);
    check("t5_head", 32'(bus.uo_out[3:0]), 32'h2);
    for (int i = 2; i <= 8; i++) begin
      check($sformatf("t5_head%0d", i), 32'(bus.uo_out[3:0]), 32'(i));
      pop();
    end
    check("t5_tail", 32'(bus.uo_out[3:0]), 32'hA);
    pop();
    check("t5_cnt_end", 32'(cnt()), 32'd0);

    bus.ui_in = 8'h37;
    tick(1);
    bus.ui_in = IDLE;
    tick(2);
    check("t6_bad", 32'(bus.uo_out[7]), 32'd1);
    check("t6_cnt", 32'(cnt()), 32'd0);
    bus.ui_in = 8'h03;
    tick(1);
    bus.ui_in = 8'h04;
    tick(1);
    bus.ui_in = IDLE;
    tick(2);
    check("t6_ab_cnt", 32'(cnt()), 32'd2);
    check("t6_ab_head", 32'(bus.uo_out[3:0]), 32'h3);
    #2 rst_n = 1'b0;
    #1;
    check("t6_rst_uo", 32'(bus.uo_out), 32'h00);
    check("t6_rst_uio", 32'(bus.uio_out), 32'h00);
    check("t6_rst_oe", 32'(bus.uio_oe), 32'hFC);
    tick(1);
    rst_n = 1'b1;
    tick(2);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
